hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 SHALL have inputs id_rs[4:0], id_rt[4:0], id_opcode[5:0]: source fields and opcode of the instruction in ID.
REQ-004 SHALL have input id_rt_is_source, 1 bit: 1 = ID instruction reads rt.
REQ-005 SHALL have inputs ex_reg_write, ex_mem_read (1 bit each) and ex_wreg[4:0]: EX-stage write enable, load flag and resolved destination.
REQ-006 SHALL have inputs mem_reg_write, mem_mem_read (1 bit each) and mem_wreg[4:0]: the same three signals for the MEM stage.
REQ-007 SHALL have inputs wb_reg_write (1 bit) and wb_wreg[4:0]: WB-stage write enable and destination.
REQ-008 SHALL have input halt_req, 1 bit: external request to drain and freeze the pipeline.
REQ-009 SHALL have outputs rs_fwd_sel[1:0], rt_fwd_sel[1:0]: operand source select; 0 = regfile, 1 = MEM value, 2 = WB value; 3 is never driven.
REQ-010 SHALL have output hazard, 1 bit: 1 = ID/EX control bits are zeroed, inserting a bubble.
REQ-011 SHALL have outputs pc_write and if_id_write, 1 bit each: 0 = PC and IF/ID are held.
REQ-012 SHALL have output halt_ack, 1 bit: 1 = pipeline drained and frozen.
REQ-013 SHALL have output stall_count[15:0]: saturating count of dependency-stall cycles.

Function
REQ-014 uses_rs SHALL be 1 unless id_opcode is 6'h02 or 6'h03; uses_rt SHALL equal id_rt_is_source; is_branch SHALL be 1 when id_opcode is 6'h04.
REQ-015 A dependency on stage X SHALL require that X's reg_write = 1, X's wreg equals the source register, the source is in use, and the source register is nonzero.
REQ-016 Forward select for each source SHALL be: 1 on a MEM dependency with mem_mem_read = 0; else 2 on a WB dependency; else 0. MEM has priority over WB.
REQ-017 Required stall cycles (need) SHALL be the maximum over both sources of:
- EX dependency with ex_mem_read = 1: 2
- EX dependency, ALU result: 1
- MEM dependency with mem_mem_read = 1: 1
- otherwise: 0
is_branch SHALL not change need.
REQ-018 FSM states SHALL be RUN, STALL, DRAIN and HALTED.
REQ-019 In RUN with need > 0: hazard = 1, pc_write = 0 and if_id_write = 0 in the same cycle (Mealy); stall_left SHALL load need-1; next state SHALL be STALL if need = 2, else RUN.
REQ-020 In RUN with need = 0 and halt_req = 0: hazard = 0, pc_write = 1, if_id_write = 1.
REQ-021 In RUN with need = 0 and halt_req = 1: the cycle SHALL behave as REQ-020; next state SHALL be DRAIN with drain_cnt = 3.
REQ-022 In STALL: hazard = 1, pc_write = 0, if_id_write = 0; stall_left SHALL decrement; next state SHALL be RUN when stall_left reaches 0. halt_req SHALL be ignored until the FSM is back in RUN.
REQ-023 In DRAIN: hazard = 1, pc_write = 0, if_id_write = 0; drain_cnt SHALL decrement each cycle; next state SHALL be HALTED after the 3rd DRAIN cycle.
REQ-024 In HALTED: hazard = 1, pc_write = 0, if_id_write = 0, halt_ack = 1; on halt_req = 0 the next state SHALL be RUN, and halt_ack SHALL be 0 in that RUN cycle.
REQ-025 halt_ack SHALL be 1 only in HALTED.
REQ-026 stall_count SHALL increment on each cycle with hazard = 1 in RUN or STALL; it SHALL not count in DRAIN or HALTED, and SHALL hold at 16'hFFFF.
REQ-027 Forward selects SHALL be combinational in every state.

Reset
REQ-028 While rst_n = 0 at a clock edge, the FSM SHALL go to RUN, with stall_left = 0, drain_cnt = 0 and stall_count = 0.
REQ-029 Outputs after reset SHALL be: hazard = 0, pc_write = 1, if_id_write = 1, halt_ack = 0; forward selects SHALL follow inputs.
REQ-030 Reset asserted in STALL, DRAIN or HALTED SHALL abandon the operation with no pending stall or halt.

Verification
REQ-031 EX: reg_write = 1, mem_read = 1, wreg = 5; ID: beq with rs = 5 -> hazard = 1 for exactly 2 cycles, pc_write = 0 both cycles, stall_count = 2.
REQ-032 MEM: reg_write = 1, ALU, wreg = 7; WB: reg_write = 1, wreg = 7; ID rs = 7, rt = 7, id_rt_is_source = 1 -> rs_fwd_sel = 1, rt_fwd_sel = 1, hazard = 0.
REQ-033 EX: reg_write = 1, wreg = 0; ID rs = 0 -> need = 0, rs_fwd_sel = 0, hazard = 0.
REQ-034 halt_req = 1 with need = 0 -> 3 DRAIN cycles (hazard = 1), then halt_ack = 1; release halt_req -> halt_ack = 0 and pc_write = 1 on the next cycle.
REQ-035 halt_req = 1 on the first of 2 load-stall cycles -> stall completes (2 cycles), then drain begins; stall_count increases by 2 only.
REQ-036 rst_n = 0 in DRAIN -> next cycle RUN, halt_ack = 0, pc_write = 1, stall_count = 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard control for a 5-stage in-order pipeline. It does three jobs:
//   - selects the operand forwarding source for rs and rt,
//   - stalls the front end (PC and IF/ID) on load-use and ALU dependencies
//     that forwarding cannot cover,
//   - drains and freezes the pipeline on an external halt request.
//
// Ports
//   clk, rst_n                      : clock, synchronous active-low reset
//   id_rs, id_rt, id_opcode         : source fields and opcode of the ID instruction
//   id_rt_is_source                 : ID instruction reads rt
//   ex_reg_write/ex_mem_read/ex_wreg    : EX stage write enable, load flag, destination
//   mem_reg_write/mem_mem_read/mem_wreg : MEM stage write enable, load flag, destination
//   wb_reg_write/wb_wreg            : WB stage write enable and destination
//   halt_req                        : request to drain and freeze the pipeline
//   rs_fwd_sel, rt_fwd_sel          : 0 = regfile, 1 = MEM value, 2 = WB value
//   hazard                          : zero the ID/EX control bits (bubble)
//   pc_write, if_id_write           : 0 = hold PC / IF/ID
//   halt_ack                        : pipeline drained and frozen
//   stall_count                     : saturating count of dependency-stall cycles

module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [5:0]  id_opcode,
    input  logic        id_rt_is_source,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_wreg,
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_wreg,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_wreg,
    input  logic        halt_req,
    output logic [1:0]  rs_fwd_sel,
    output logic [1:0]  rt_fwd_sel,
    output logic        hazard,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        halt_ack,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;

    state_t      state_q, state_d;
    logic [1:0]  stall_left_q, stall_left_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic        uses_rs, uses_rt, is_branch;
    logic [1:0]  need_rs, need_rt, need;

    // A stage matters for a source only if it writes that exact, nonzero
    // register and the ID instruction actually reads the source.
    function automatic logic dep(input logic wr, input logic [4:0] wreg,
                                 input logic [4:0] src, input logic used);
        return wr && used && (src != 5'd0) && (wreg == src);
    endfunction

    // Stall cycles a single source needs: a load still in EX costs two,
    // an ALU result in EX or a load in MEM costs one.
    function automatic logic [1:0] src_need(input logic [4:0] src, input logic used);
        logic [1:0] n;
        n = 2'd0;
        if (dep(ex_reg_write, ex_wreg, src, used))
            n = ex_mem_read ? 2'd2 : 2'd1;
        else if (dep(mem_reg_write, mem_wreg, src, used) && mem_mem_read)
            n = 2'd1;
        return n;
    endfunction

    // MEM has priority over WB; a load still in MEM has no value to forward
    // yet, so it falls through to the WB check.
    function automatic logic [1:0] fwd(input logic [4:0] src, input logic used);
        logic [1:0] s;
        s = 2'd0;
        if (dep(mem_reg_write, mem_wreg, src, used) && !mem_mem_read)
            s = 2'd1;
        else if (dep(wb_reg_write, wb_wreg, src, used))
            s = 2'd2;
        return s;
    endfunction

    always_comb begin
        uses_rs   = !((id_opcode == OP_J) || (id_opcode == OP_JAL));
        uses_rt   = id_rt_is_source;
        // Branches resolve in EX here, so they need no extra stall cycles;
        // the decode is kept for visibility only.
        is_branch = (id_opcode == OP_BEQ);

        need_rs = src_need(id_rs, uses_rs);
        need_rt = src_need(id_rt, uses_rt);
        need    = (need_rs > need_rt) ? need_rs : need_rt;

        rs_fwd_sel = fwd(id_rs, uses_rs);
        rt_fwd_sel = fwd(id_rt, uses_rt);
    end

    // Next-state and Mealy outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d       = state_q;
        stall_left_d  = stall_left_q;
        drain_cnt_d   = drain_cnt_q;
        stall_count_d = stall_count_q;
        hazard        = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        halt_ack      = 1'b0;

        unique case (state_q)
            RUN: begin
                // A dependency stall wins over a halt request; the halt is
                // taken on the first clean RUN cycle afterwards.
                if (need != 2'd0) begin
                    hazard       = 1'b1;
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    stall_left_d = need - 2'd1;
                    state_d      = (need == 2'd2) ? STALL : RUN;
                end else if (halt_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 2'd3;
                end
            end
            STALL: begin
                hazard      = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if (stall_left_q <= 2'd1) begin
                    stall_left_d = 2'd0;
                    state_d      = RUN;
                end else begin
                    stall_left_d = stall_left_q - 2'd1;
                end
            end
            DRAIN: begin
                hazard      = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                drain_cnt_d = (drain_cnt_q != 2'd0) ? drain_cnt_q - 2'd1 : 2'd0;
                if (drain_cnt_q <= 2'd1)
                    state_d = HALTED;
            end
            HALTED: begin
                hazard      = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                halt_ack    = 1'b1;
                if (!halt_req)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        // Only dependency stalls are counted, not drain/halt bubbles.
        if (hazard && ((state_q == RUN) || (state_q == STALL))
            && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            stall_left_q  <= 2'd0;
            drain_cnt_q   <= 2'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stall_left_q  <= stall_left_d;
            drain_cnt_q   <= drain_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

    logic unused_ok;
    assign unused_ok = is_branch;

endmodule
